// File: rtl/regfile_mp_scoreboard.sv
// -----------------------------------------------------------------------------
// regfile_mp_scoreboard
//   Integer register file with two combinational read ports, two synchronous
//   write ports (A and B), optional same-cycle write-to-read bypass, a
//   per-register busy scoreboard, a registered write-conflict pulse and a
//   never-bypassed debug read port.
//
// Ports
//   clk, reset_n            rising-edge clock, asynchronous active-low reset
//   rs1_addr / rs2_addr     read addresses
//   rs1_data / rs2_data     read data (combinational)
//   rs1_busy / rs2_busy     scoreboard bit of the read address (combinational)
//   wa_en/wa_addr/wa_data   write port A
//   wb_en/wb_addr/wb_data   write port B (wins a same-address collision)
//   iss_en / iss_addr       mark a destination register busy
//   dbg_addr / dbg_data     debug read of the array only
//   wr_conflict             one-cycle pulse after A and B hit the same register
// -----------------------------------------------------------------------------
module regfile_mp_scoreboard #(
   parameter int XLEN     = 64,
   parameter int NREGS    = 32,
   parameter int AW       = 5,
   parameter int BYPASS   = 1,
   parameter int ZERO_REG = 1
) (
   input  logic            clk,
   input  logic            reset_n,
   input  logic [AW-1:0]   rs1_addr,
   input  logic [AW-1:0]   rs2_addr,
   output logic [XLEN-1:0] rs1_data,
   output logic [XLEN-1:0] rs2_data,
   output logic            rs1_busy,
   output logic            rs2_busy,
   input  logic            wa_en,
   input  logic [AW-1:0]   wa_addr,
   input  logic [XLEN-1:0] wa_data,
   input  logic            wb_en,
   input  logic [AW-1:0]   wb_addr,
   input  logic [XLEN-1:0] wb_data,
   input  logic            iss_en,
   input  logic [AW-1:0]   iss_addr,
   input  logic [AW-1:0]   dbg_addr,
   output logic [XLEN-1:0] dbg_data,
   output logic            wr_conflict
);

   // Storage spans the full address space so any address indexes cleanly;
   // entries at or above NREGS are never written and stay at zero.
   localparam int          DEPTH   = 1 << AW;
   localparam logic [AW:0] NREGS_W = NREGS[AW:0];

   logic [XLEN-1:0]  regs_r [DEPTH];
   logic [DEPTH-1:0] busy_r;
   logic             wr_conflict_r;

   logic wa_ok_s;
   logic wb_ok_s;
   logic iss_ok_s;
   logic conflict_s;

   // Address lies inside the implemented register range.
   function automatic logic in_range(input logic [AW-1:0] a);
      return ({1'b0, a} < NREGS_W);
   endfunction

   // Address names a real, writable register (excludes hardwired zero).
   function automatic logic addr_ok(input logic [AW-1:0] a);
      logic ok;
      if (ZERO_REG != 0) begin
         ok = in_range(a) && (a != {AW{1'b0}});
      end else begin
         ok = in_range(a);
      end
      return ok;
   endfunction

   // Read data: B bypass over A bypass over the array.
   function automatic logic [XLEN-1:0] rd_data(input logic [AW-1:0] a);
      logic [XLEN-1:0] d;
      d = {XLEN{1'b0}};
      if (!addr_ok(a)) begin
         d = {XLEN{1'b0}};
      end else if ((BYPASS != 0) && wb_ok_s && (wb_addr == a)) begin
         d = wb_data;
      end else if ((BYPASS != 0) && wa_ok_s && (wa_addr == a)) begin
         d = wa_data;
      end else begin
         d = regs_r[a];
      end
      return d;
   endfunction

   // Busy bit: a bypassed write means the value is already available.
   function automatic logic rd_busy(input logic [AW-1:0] a);
      logic b;
      b = 1'b0;
      if (!addr_ok(a)) begin
         b = 1'b0;
      end else if ((BYPASS != 0) && ((wb_ok_s && (wb_addr == a)) ||
                                     (wa_ok_s && (wa_addr == a)))) begin
         b = 1'b0;
      end else begin
         b = busy_r[a];
      end
      return b;
   endfunction

   // Qualify write and issue requests; the collision check still covers r0.
   always_comb begin
      wa_ok_s    = wa_en && addr_ok(wa_addr);
      wb_ok_s    = wb_en && addr_ok(wb_addr);
      iss_ok_s   = iss_en && addr_ok(iss_addr);
      conflict_s = wa_en && wb_en && (wa_addr == wb_addr) && in_range(wa_addr);
   end

   // Register array: port B is applied last so it wins a collision.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            regs_r[i] <= {XLEN{1'b0}};
         end
      end else begin
         for (int i = 0; i < DEPTH; i++) begin
            if (wb_ok_s && (wb_addr == AW'(i))) begin
               regs_r[i] <= wb_data;
            end else if (wa_ok_s && (wa_addr == AW'(i))) begin
               regs_r[i] <= wa_data;
            end else begin
               regs_r[i] <= regs_r[i];
            end
         end
      end
   end

   // Scoreboard: a new issue outranks a writeback from the older producer.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         busy_r <= {DEPTH{1'b0}};
      end else begin
         for (int i = 0; i < DEPTH; i++) begin
            if (iss_ok_s && (iss_addr == AW'(i))) begin
               busy_r[i] <= 1'b1;
            end else if ((wa_ok_s && (wa_addr == AW'(i))) ||
                         (wb_ok_s && (wb_addr == AW'(i)))) begin
               busy_r[i] <= 1'b0;
            end else begin
               busy_r[i] <= busy_r[i];
            end
         end
      end
   end

   // Conflict pulse, visible for the single cycle after the collision.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_conflict_r <= 1'b0;
      end else begin
         wr_conflict_r <= conflict_s;
      end
   end

   // Read, busy and debug ports.
   always_comb begin
      rs1_data = rd_data(rs1_addr);
      rs2_data = rd_data(rs2_addr);
      rs1_busy = rd_busy(rs1_addr);
      rs2_busy = rd_busy(rs2_addr);
      if (addr_ok(dbg_addr)) begin
         dbg_data = regs_r[dbg_addr];
      end else begin
         dbg_data = {XLEN{1'b0}};
      end
   end

   assign wr_conflict = wr_conflict_r;

endmodule
